// File: rtl/adder8_arbiter.sv
// Round-robin arbiter that shares one external ripple adder between two requesters
// and returns each registered result on a single response channel tagged by id.
module adder8_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_ovfl,
  input  logic             add_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_s,
  output logic             rsp_ovfl,
  output logic             rsp_cout,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_NEG = 2'b10;
  localparam logic [1:0] OP_INC = 2'b11;

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] add_a_q, add_a_d;
  logic [WIDTH-1:0] add_b_q, add_b_d;
  logic             add_cin_q, add_cin_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_s_q, rsp_s_d;
  logic             rsp_ovfl_q, rsp_ovfl_d;
  logic             rsp_cout_q, rsp_cout_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             busy_q, busy_d;

  logic             grant_vld_c;
  logic             grant_id_c;
  logic [1:0]       sel_op_c;
  logic [WIDTH-1:0] sel_a_c;
  logic [WIDTH-1:0] sel_b_c;

  // Arbitration: on contention the requester not served last wins.
  always_comb begin
    grant_vld_c = req0_valid | req1_valid;
    grant_id_c  = !req0_valid;
    if (req0_valid && req1_valid) begin
      grant_id_c = ~last_q;
    end
    sel_op_c = grant_id_c ? req1_op : req0_op;
    sel_a_c  = grant_id_c ? req1_a  : req0_a;
    sel_b_c  = grant_id_c ? req1_b  : req0_b;
  end

  assign req0_ready = (state_q == IDLE) && grant_vld_c && !grant_id_c;
  assign req1_ready = (state_q == IDLE) && grant_vld_c &&  grant_id_c;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    add_a_d    = add_a_q;
    add_b_d    = add_b_q;
    add_cin_d  = add_cin_q;
    rsp_id_d   = rsp_id_q;
    rsp_s_d    = rsp_s_q;
    rsp_ovfl_d = rsp_ovfl_q;
    rsp_cout_d = rsp_cout_q;
    case (state_q)
      IDLE: begin
        if (grant_vld_c) begin
          rsp_id_d = grant_id_c;
          state_d  = EXEC;
          case (sel_op_c)
            OP_ADD: begin add_a_d = sel_a_c; add_b_d = sel_b_c;  add_cin_d = 1'b0; end
            OP_SUB: begin add_a_d = sel_a_c; add_b_d = ~sel_b_c; add_cin_d = 1'b1; end
            OP_NEG: begin add_a_d = '0;      add_b_d = ~sel_a_c; add_cin_d = 1'b1; end
            OP_INC: begin add_a_d = sel_a_c; add_b_d = '0;       add_cin_d = 1'b1; end
            default: begin add_a_d = sel_a_c; add_b_d = sel_b_c; add_cin_d = 1'b0; end
          endcase
        end
      end
      EXEC: begin
        rsp_s_d    = add_s;
        rsp_ovfl_d = add_ovfl;
        rsp_cout_d = add_cout;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          last_d  = rsp_id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    rsp_valid_d = (state_d == RESP);
    busy_d      = (state_d != IDLE);
  end

  // Pointer resets to "1 served last" so req0 wins the first contention.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_cin_q   <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_s_q     <= '0;
      rsp_ovfl_q  <= 1'b0;
      rsp_cout_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_cin_q   <= add_cin_d;
      rsp_id_q    <= rsp_id_d;
      rsp_s_q     <= rsp_s_d;
      rsp_ovfl_q  <= rsp_ovfl_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_cin   = add_cin_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_s     = rsp_s_q;
  assign rsp_ovfl  = rsp_ovfl_q;
  assign rsp_cout  = rsp_cout_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_adder8_arbiter.sv
// Scoreboard bench for adder8_arbiter: directed ops with hand-computed results,
// a behavioural 8-bit adder on the datapath side, and a decoupled response monitor.
module tb_adder8_arbiter;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [W-1:0] add_a, add_b, add_s;
  logic         add_cin, add_ovfl, add_cout;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_ovfl, rsp_cout, busy;
  logic [W-1:0] rsp_s;
  logic [W:0]   sum9;

  always #5 clk = ~clk;

  adder8_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_ovfl(add_ovfl), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_s(rsp_s), .rsp_ovfl(rsp_ovfl), .rsp_cout(rsp_cout), .busy(busy)
  );

  // Behavioural ripple adder standing in for the shared datapath.
  always_comb sum9 = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
  assign add_s    = sum9[W-1:0];
  assign add_cout = sum9[W];
  assign add_ovfl = (add_a[W-1] == add_b[W-1]) && (add_s[W-1] != add_a[W-1]);

  typedef struct {
    logic         id;
    logic [W-1:0] s;
    logic         o;
    logic         c;
    int           acc;
  } exp_t;

  exp_t sb[$];
  exp_t pend[2];
  int   grant_ids[$];
  int   grant_cyc[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   last_rsp_cyc = 0;
  logic prev_rv = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic log_grant(input int id);
    exp_t e;
    e     = pend[id];
    e.id  = id[0];
    e.acc = cyc;
    sb.push_back(e);
    grant_ids.push_back(id);
    grant_cyc.push_back(cyc);
  endtask

  // Monitor: records handshakes into the scoreboard and checks every response.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      prev_rv = 1'b0;
    end else begin
      if (req0_ready && req1_ready) chk("dual_ready", 1, 0);
      if (req0_ready) begin chk("ready0_needs_valid", int'(req0_valid), 1); log_grant(0); end
      if (req1_ready) begin chk("ready1_needs_valid", int'(req1_valid), 1); log_grant(1); end
      if (rsp_valid && !prev_rv) begin
        if (sb.size() == 0) chk("unexpected_rsp", 1, 0);
        else chk("latency", cyc - sb[0].acc, 2);
        chk("busy_in_resp", int'(busy), 1);
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          chk("rsp_without_expect", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_id",   int'(rsp_id),   int'(e.id));
          chk("rsp_s",    int'(rsp_s),    int'(e.s));
          chk("rsp_ovfl", int'(rsp_ovfl), int'(e.o));
          chk("rsp_cout", int'(rsp_cout), int'(e.c));
        end
        last_rsp_cyc = cyc;
      end
      prev_rv = rsp_valid;
    end
  end

  task automatic set_req(input int id, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] es,
                         input logic eo, input logic ec);
    pend[id].s = es;
    pend[id].o = eo;
    pend[id].c = ec;
    if (id == 0) begin
      req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
    end else begin
      req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
    end
  endtask

  task automatic wait_grant(input int n);
    for (int i = 0; i < 50 && grant_ids.size() < n; i++) begin
      @(negedge clk); #1;
    end
    if (grant_ids.size() < n) chk("grant_timeout", grant_ids.size(), n);
  endtask

  task automatic wait_drain();
    int i;
    for (i = 0; i < 50 && (sb.size() != 0 || rsp_valid); i++) begin
      @(negedge clk); #1;
    end
    if (i == 50) chk("drain_timeout", sb.size(), 0);
  endtask

  task automatic drop_all();
    @(posedge clk); #2;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic issue(input int id, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] es,
                       input logic eo, input logic ec);
    @(posedge clk); #2;
    grant_ids.delete(); grant_cyc.delete();
    set_req(id, op, a, b, es, eo, ec);
    wait_grant(1);
    if (grant_ids.size() > 0) chk("single_grant_id", grant_ids[0], id);
    drop_all();
    wait_drain();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rsp_valid"}, int'(rsp_valid), 0);
    chk({tag, "_busy"},      int'(busy), 0);
    chk({tag, "_ready"},     int'({req0_ready, req1_ready}), 0);
    chk({tag, "_add_ops"},   int'({add_a, add_b, add_cin}), 0);
    chk({tag, "_rsp_data"},  int'({rsp_id, rsp_s, rsp_ovfl, rsp_cout}), 0);
  endtask

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = 2'b00; req1_op = 2'b00;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    @(negedge clk); @(negedge clk); #1;
    chk_reset_outputs("por");
    @(posedge clk); #2 rst_n = 1'b1;

    // Single-requester directed ops.
    issue(0, 2'b00, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0);
    issue(1, 2'b01, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0);
    issue(1, 2'b01, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
    issue(0, 2'b10, 8'h05, 8'hAA, 8'hFB, 1'b0, 1'b0);
    issue(1, 2'b10, 8'h80, 8'h55, 8'h80, 1'b1, 1'b0);
    issue(0, 2'b11, 8'h7F, 8'h33, 8'h80, 1'b1, 1'b0);
    issue(1, 2'b11, 8'hFF, 8'hCC, 8'h00, 1'b0, 1'b1);

    // Continuous contention: alternating grants three cycles apart.
    @(posedge clk); #2;
    grant_ids.delete(); grant_cyc.delete();
    set_req(0, 2'b00, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0);
    set_req(1, 2'b01, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0);
    wait_grant(4);
    drop_all();
    if (grant_ids.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("rr_order", grant_ids[i], i % 2);
      for (int i = 1; i < 4; i++) chk("rr_spacing", grant_cyc[i] - grant_cyc[i-1], 3);
    end
    wait_drain();

    // Back-pressure: response held stable, then the other requester is served.
    @(posedge clk); #2;
    rsp_ready = 1'b0;
    grant_ids.delete(); grant_cyc.delete();
    set_req(0, 2'b00, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0);
    set_req(1, 2'b01, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0);
    wait_grant(1);
    if (grant_ids.size() > 0) chk("bp_first_grant", grant_ids[0], 0);
    for (int i = 0; i < 10 && !rsp_valid; i++) begin @(negedge clk); #1; end
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", int'(rsp_valid), 1);
      chk("bp_hold_data", int'({rsp_id, rsp_s, rsp_ovfl, rsp_cout}), int'({1'b0, 8'h30, 2'b00}));
      chk("bp_ready_low", int'({req0_ready, req1_ready}), 0);
      @(negedge clk); #1;
    end
    @(posedge clk); #2 rsp_ready = 1'b1;
    wait_grant(2);
    if (grant_ids.size() >= 2) begin
      chk("bp_second_grant", grant_ids[1], 1);
      chk("bp_regrant_delay", grant_cyc[1] - last_rsp_cyc, 1);
    end
    drop_all();
    wait_drain();

    // Reset during EXEC: op discarded, reset values restored, req0 wins next.
    @(posedge clk); #2;
    grant_ids.delete(); grant_cyc.delete();
    set_req(0, 2'b00, 8'h11, 8'h22, 8'h33, 1'b0, 1'b0);
    wait_grant(1);
    @(posedge clk); #2;
    chk("exec_busy", int'(busy), 1);
    rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk); #1;
    chk_reset_outputs("mid_rst");
    for (int i = 0; i < 5; i++) begin @(negedge clk); #1; end
    chk("no_rsp_after_rst", int'(rsp_valid), 0);
    @(posedge clk); #2;
    grant_ids.delete(); grant_cyc.delete();
    set_req(0, 2'b00, 8'h40, 8'h40, 8'h80, 1'b1, 1'b0);
    set_req(1, 2'b11, 8'h01, 8'h00, 8'h02, 1'b0, 1'b0);
    wait_grant(1);
    if (grant_ids.size() > 0) chk("post_rst_grant", grant_ids[0], 0);
    drop_all();
    wait_drain();

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder8_arbiter.md
Name: adder8_arbiter

Overview:
Shares one 8-bit ripple adder (a, b, carry-in in; sum, signed overflow, carry-out back) between two requesters. The block arbitrates round-robin, maps each request's opcode onto adder operands and carry-in, registers the result, and returns it on a single response channel tagged with the requester id. It sits between the sign-change/display front end and the adder datapath.

Parameters:
WIDTH, 8, operand/result width. It must match the adder instance; only 8 is verified.

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_op  in  2  00 ADD, 01 SUB, 10 NEG, 11 INC
req0_a  in  WIDTH  operand A
req0_b  in  WIDTH  operand B (ignored for NEG/INC)
req1_valid, req1_ready, req1_op, req1_a, req1_b  as requester 0
add_a  out  WIDTH  adder operand A
add_b  out  WIDTH  adder operand B
add_cin  out  1  adder carry-in
add_s  in  WIDTH  adder sum
add_ovfl  in  1  adder signed overflow
add_cout  in  1  adder carry-out
rsp_valid  out  1  result available
rsp_ready  in  1  consumer takes result
rsp_id  out  1  requester that issued the result
rsp_s  out  WIDTH  result
rsp_ovfl  out  1  signed overflow of result
rsp_cout  out  1  carry-out of result
busy  out  1  high in EXEC or RESP

Behaviour:
- FSM states IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE: if no valid, stay. If exactly one valid, grant it. If both are valid, grant the requester not granted last. The round-robin pointer resets so that req0 wins the first contention.
- reqN_ready = (state==IDLE) && granted==N. This is combinational and high for exactly one cycle per accepted op. On handshake, capture op/a/b and the id, then move to EXEC.
- Operand mapping is registered at capture, so add_a/add_b/add_cin are flop outputs held until the next capture:
  - ADD: a, b, 0.
  - SUB: a, ~b, 1.
  - NEG: 0x00, ~a, 1.
  - INC: a, 0x00, 1.
- EXEC (one cycle): the adder settles combinationally. At the end of EXEC, register add_s/add_ovfl/add_cout into rsp_s/rsp_ovfl/rsp_cout, then move to RESP.
- RESP: rsp_valid=1, with rsp_id/rsp_s/rsp_ovfl/rsp_cout held stable until rsp_ready=1. On rsp_valid&&rsp_ready, update the pointer to the served id and return to IDLE. Both req ready signals are 0 throughout EXEC and RESP.
- Latency: handshake at cycle T produces rsp_valid at T+2. Minimum spacing between accepts is 3 cycles.
- Flags are passed through from the adder unmodified. cout of SUB means "no borrow".
- Requester valid may drop before grant without penalty. No request is queued. Operands are sampled only at handshake.
- Reset values: all ready signals 0, rsp_valid 0, rsp_id 0, rsp_s 0, rsp_ovfl 0, rsp_cout 0, add_a 0, add_b 0, add_cin 0, busy 0.
- rst_n low in any state: the next edge returns the block to IDLE with all reset values. An in-flight op is discarded and no response is emitted.
- A request valid in the same cycle as the RESP handshake is not accepted until the following IDLE cycle.

Test Plan:
1. Reset, then req0 ADD a=0x05 b=0x03 -> req0_ready at T, rsp_valid at T+2 with id=0, s=0x08, ovfl=0, cout=0.
2. req1 SUB 0x10-0x20 -> s=0xF0, ovfl=0, cout=0. Then SUB 0x80-0x01 -> s=0x7F, ovfl=1, cout=1.
3. NEG a=0x05 -> s=0xFB. NEG a=0x80 -> s=0x80, ovfl=1. INC 0x7F -> 0x80, ovfl=1. INC 0xFF -> 0x00, cout=1, ovfl=0.
4. Both requesters valid continuously with rsp_ready=1 -> grant order 0,1,0,1. Each rsp_id matches its grant, and accepts are spaced exactly 3 cycles apart.
5. rsp_ready held 0 for 5 cycles in RESP -> rsp_* stable and both ready signals 0. Release -> IDLE next cycle, and the other requester is granted.
6. rst_n low for one cycle during EXEC -> rsp_valid never rises for that op and all outputs return to reset values. With both valid afterward, req0 is granted first.
